// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Responder end of the MEM-stage data-memory interface. Accepts one load or
// store at a time over a valid/ready handshake, waits WAIT_STATES cycles,
// then performs the access against an internal word-addressed array and
// emits a single-cycle response carrying extended load data or an error.
// The multi-cycle latency lets the hazard unit stall the pipeline on busy.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   reqValid     request present
//   reqReady     responder idle and able to accept (low during reset)
//   reqWrite     1 = store, 0 = load
//   reqAddress   byte address
//   reqFunct3    RISC-V access size/extension code
//   reqWriteData right-aligned store data
//   respValid    one-cycle response pulse
//   respReadData extended load data (0 for stores and errors)
//   respError    request rejected, no side effect (qualified by respValid)
//   busy         high from the accept cycle through the response cycle
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqWriteData,
  output logic        respValid,
  output logic [31:0] respReadData,
  output logic        respError,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic        cap_write;
  logic [31:0] cap_address;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  // Fields of the access being performed. With zero wait states the access
  // happens on the accept edge itself, so the live request is used in IDLE.
  logic        f_write;
  logic [31:0] f_address;
  logic [2:0]  f_funct3;
  logic [31:0] f_wdata;

  logic [IDX_W-1:0] idx;
  logic             err;
  logic [3:0]       lane_en;
  logic [31:0]      lane_data;
  logic [31:0]      load_data;
  logic             enter_respond;

  // Select the byte/halfword lane(s) of a word and extend per funct3.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    extend_load = {{24{b[7]}}, b};
      3'd1:    extend_load = {{16{h[15]}}, h};
      3'd4:    extend_load = {24'd0, b};
      3'd5:    extend_load = {16'd0, h};
      default: extend_load = word;
    endcase
  endfunction

  always_comb begin
    if (state == IDLE) begin
      f_write   = reqWrite;
      f_address = reqAddress;
      f_funct3  = reqFunct3;
      f_wdata   = reqWriteData;
    end else begin
      f_write   = cap_write;
      f_address = cap_address;
      f_funct3  = cap_funct3;
      f_wdata   = cap_wdata;
    end
  end

  assign idx = f_address[IDX_W+1:2];

  always_comb begin
    err = 1'b0;
    if ({2'b00, f_address[31:2]} >= 32'(DEPTH_WORDS)) err = 1'b1;
    if (f_write) begin
      if (f_funct3 > 3'd2) err = 1'b1;
    end else if (f_funct3 == 3'd3 || f_funct3[2:1] == 2'b11) begin
      err = 1'b1;
    end
    if (f_funct3[1:0] == 2'b01 && f_address[0]) err = 1'b1;
    if (f_funct3[1:0] == 2'b10 && f_address[1:0] != 2'b00) err = 1'b1;
  end

  // Replicate store data across lanes so each enabled lane sees its bytes.
  always_comb begin
    case (f_funct3[1:0])
      2'b00: begin
        lane_en   = 4'b0001 << f_address[1:0];
        lane_data = {4{f_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = f_address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{f_wdata[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = f_wdata;
      end
    endcase
  end

  assign load_data = extend_load(mem[idx], f_address[1:0], f_funct3);

  assign enter_respond = ((state == IDLE) && reqValid && (WAIT_STATES == 0)) ||
                         ((state == WAIT) && (cnt == 4'd0));

  assign reqReady = reset && (state == IDLE);
  assign busy     = reset && ((state != IDLE) || reqValid);

  // Array write shares the RESPOND-entry edge with the read-data register;
  // reset on that edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && enter_respond && f_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      respValid    <= 1'b0;
      respError    <= 1'b0;
      respReadData <= 32'd0;
    end else begin
      if (enter_respond) begin
        state        <= RESPOND;
        respValid    <= 1'b1;
        respError    <= err;
        respReadData <= (err || f_write) ? 32'd0 : load_data;
      end else begin
        respValid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (reqValid) begin
            cap_write   <= reqWrite;
            cap_address <= reqAddress;
            cap_funct3  <= reqFunct3;
            cap_wdata   <= reqWriteData;
            cnt         <= CNT_INIT;
            if (WAIT_STATES > 0) state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
